// File: rtl/cvp14_core.sv
// cvp14_core: 16-bit multi-cycle core (IDLE/FETCH/EXEC/LDWB/HALTED) on a single-port word memory.
// Optional feature macro: CVP14_BZ_EN turns opcode 1101 into BZ (branch if R[rd] == 0).
module cvp14_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_LDWB, S_HALTED} state_e;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_LD  = 4'h8, OP_ST  = 4'h9, OP_SLL = 4'hA, OP_SLH = 4'hB,
                         OP_J   = 4'hC, OP_BZ  = 4'hD, OP_HALT = 4'hF;

  state_e            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  // Only the destination field of IR is consumed after EXEC (by LDWB).
  logic [2:0]        ir_rd_q, ir_rd_d;
  logic [7:0][15:0]  rf_q, rf_d;
  logic              v_q, v_d;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] a, b, sum, diff, ea, pc_inc;

  assign op     = DataIn[15:12];
  assign rd     = DataIn[11:9];
  assign rs     = DataIn[8:6];
  assign rt     = DataIn[5:3];
  assign a      = rf_q[rs];
  assign b      = rf_q[rt];
  assign sum    = a + b;
  assign diff   = a - b;
  assign ea     = a + {10'd0, DataIn[5:0]};
  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_rd_d = ir_rd_q;
    rf_d    = rf_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        ir_rd_d = rd;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (op)
          OP_ADD: begin
            rf_d[rd] = sum;
            v_d      = (a[15] == b[15]) && (sum[15] != a[15]);
          end
          OP_SUB: begin
            rf_d[rd] = diff;
            v_d      = (a[15] != b[15]) && (diff[15] != a[15]);
          end
          OP_AND:  rf_d[rd] = a & b;
          OP_OR:   rf_d[rd] = a | b;
          OP_LD:   state_d = S_LDWB;
          OP_SLL:  rf_d[rd][7:0]  = DataIn[7:0];
          OP_SLH:  rf_d[rd][15:8] = DataIn[7:0];
          OP_J:    pc_d = pc_inc + {{4{DataIn[11]}}, DataIn[11:0]};
`ifdef CVP14_BZ_EN
          OP_BZ:   if (rf_q[rd] == 16'h0000) pc_d = pc_inc + {{7{DataIn[8]}}, DataIn[8:0]};
`endif
          OP_HALT: state_d = S_HALTED;
          default: ;
        endcase
      end
      S_LDWB: begin
        rf_d[ir_rd_q] = DataIn;
        state_d       = S_FETCH;
      end
      default: ;
    endcase
  end

  // Bus strobes follow state directly so an asynchronous reset kills an access at once.
  always_comb begin
    RD      = 1'b0;
    WR      = 1'b0;
    Addr    = 16'h0000;
    DataOut = 16'h0000;
    case (state_q)
      S_FETCH: begin
        RD   = 1'b1;
        Addr = pc_q;
      end
      S_EXEC: begin
        if (op == OP_LD) begin
          RD   = 1'b1;
          Addr = ea;
        end else if (op == OP_ST) begin
          WR      = 1'b1;
          Addr    = ea;
          DataOut = rf_q[rd];
        end
      end
      default: ;
    endcase
  end

  assign V = v_q;

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_rd_q <= 3'd0;
      rf_q    <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_rd_q <= ir_rd_d;
      rf_q    <= rf_d;
      v_q     <= v_d;
    end
  end
endmodule

// File: tb/tb_cvp14_core.sv
// Bench for cvp14_core: ISA-level model expands each program into an expected per-cycle bus trace.
module tb_cvp14_core;
  logic        Clk1 = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] DataIn = 16'h0000;
  logic [15:0] Addr, DataOut;
  logic        RD, WR, V;

  cvp14_core #(.RESET_PC(16'h0000)) dut (
    .Clk1(Clk1), .Reset(Reset), .DataIn(DataIn), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .V(V)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        v;
  } bus_t;

  bus_t        exp_q[$];
  bus_t        e_cur;
  logic [15:0] mem [0:65535] = '{default: 16'h0000};
  logic [15:0] mm  [0:65535] = '{default: 16'h0000};
  logic [15:0] prog[$];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a = 16'h0000, ld_d = 16'h0000;
  int          checks = 0, errors = 0, cyc = 0;
  bit          chk_en = 1'b0;

  // DRAM: samples Addr/RD/WR at the rising edge; loader port used only while core is held in reset
  always @(posedge Clk1) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (WR) mem[Addr] <= DataOut;
    if (RD) DataIn <= mem[Addr];
  end

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  always @(negedge Clk1) begin
    if (chk_en && exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      chk1 ($sformatf("RD@%0d", cyc),      RD,      e_cur.rd);
      chk1 ($sformatf("WR@%0d", cyc),      WR,      e_cur.wr);
      chk16($sformatf("Addr@%0d", cyc),    Addr,    e_cur.a);
      chk16($sformatf("DataOut@%0d", cyc), DataOut, e_cur.d);
      chk1 ($sformatf("V@%0d", cyc),       V,       e_cur.v);
      cyc++;
    end
  end

  function automatic void push(input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic v);
    bus_t t;
    t.rd = r; t.wr = w; t.a = a; t.d = d; t.v = v;
    exp_q.push_back(t);
  endfunction

  // Architectural interpreter: each instruction contributes its fetch, execute and (LD) writeback cycles
  task automatic build_trace(input int n);
    logic [15:0] r [8];
    logic [15:0] pc, ins, ea;
    logic [2:0]  d_, s_, t_;
    logic        v;
    bit          halted;
    int          sa, sb, sres;
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    pc = 16'h0000; v = 1'b0; halted = 1'b0;
    exp_q.delete();
    cyc = 0;
    push(0, 0, 16'h0, 16'h0, v);
    while (exp_q.size() < n) begin
      if (halted) push(0, 0, 16'h0, 16'h0, v);
      else begin
        ins = mm[pc];
        d_ = ins[11:9]; s_ = ins[8:6]; t_ = ins[5:3];
        push(1, 0, pc, 16'h0, v);
        ea = r[s_] + {10'd0, ins[5:0]};
        pc = pc + 16'd1;
        sa = $signed(r[s_]);
        sb = $signed(r[t_]);
        case (ins[15:12])
          4'h0, 4'h1: begin
            sres = (ins[15:12] == 4'h0) ? sa + sb : sa - sb;
            push(0, 0, 16'h0, 16'h0, v);
            v = (sres > 32767) || (sres < -32768);
            r[d_] = 16'(sres);
          end
          4'h2: begin r[d_] = r[s_] & r[t_]; push(0, 0, 16'h0, 16'h0, v); end
          4'h3: begin r[d_] = r[s_] | r[t_]; push(0, 0, 16'h0, 16'h0, v); end
          4'h8: begin
            push(1, 0, ea, 16'h0, v);
            push(0, 0, 16'h0, 16'h0, v);
            r[d_] = mm[ea];
          end
          4'h9: begin push(0, 1, ea, r[d_], v); mm[ea] = r[d_]; end
          4'hA: begin r[d_] = {r[d_][15:8], ins[7:0]}; push(0, 0, 16'h0, 16'h0, v); end
          4'hB: begin r[d_] = {ins[7:0], r[d_][7:0]}; push(0, 0, 16'h0, 16'h0, v); end
          4'hC: begin
            pc = 16'(int'(pc) + $signed(ins[11:0]));
            push(0, 0, 16'h0, 16'h0, v);
          end
`ifdef CVP14_BZ_EN
          4'hD: begin
            if (r[d_] == 16'h0000) pc = 16'(int'(pc) + $signed(ins[8:0]));
            push(0, 0, 16'h0, 16'h0, v);
          end
`endif
          4'hF: begin push(0, 0, 16'h0, 16'h0, v); halted = 1'b1; end
          default: push(0, 0, 16'h0, 16'h0, v);
        endcase
      end
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge Clk1);
    ld_a = a; ld_d = d; ld_en = 1'b1; mm[a] = d;
    @(negedge Clk1);
    ld_en = 1'b0;
  endtask

  task automatic load(input logic [15:0] base);
    poke(16'h0000, 16'hC000 | (base - 16'd1));   // J from reset PC to the program
    foreach (prog[i]) poke(base + 16'(i), prog[i]);
  endtask

  task automatic run(input int n, input string nm);
    int k;
    build_trace(n);
    @(posedge Clk1); #1;
    Reset = 1'b1;
    chk_en = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < n + 20) begin
      @(posedge Clk1);
      k++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s trace timeout: %0d entries left, required 0", nm, exp_q.size());
    end
    #1;
    chk_en = 1'b0;
    Reset = 1'b0;
  endtask

  initial begin
    int k, diffs;
    #1;
    chk1("reset RD", RD, 1'b0);
    chk1("reset WR", WR, 1'b0);
    chk16("reset Addr", Addr, 16'h0000);
    chk16("reset DataOut", DataOut, 16'h0000);
    chk1("reset V", V, 1'b0);

    // overflow, AND/OR keep V, J +1 skip, SUB clears V, HALT for 100+ cycles
    prog = '{16'hA2FF, 16'hB27F, 16'h0448, 16'h9405, 16'h2A50, 16'h9A07,
             16'hC001, 16'h9A09, 16'h3C40, 16'h9C08, 16'h1800, 16'hF000};
    load(16'h0020);
    run(140, "overflow");
    chk16("mem5 add overflow", mem[5], 16'hFFFE);
    chk16("mem7 and", mem[7], 16'h7FFE);
    chk16("mem8 or", mem[8], 16'h7FFF);
    chk16("mem9 skipped by J", mem[9], 16'h0000);
    chk16("model mem5", mm[5], 16'hFFFE);
    chk16("model mem7", mm[7], 16'h7FFE);

    // load/store, src==dst collision, effective-address wrap
    prog = '{16'h8605, 16'h9606, 16'h06D8, 16'h9607, 16'hA2FF, 16'hB2FF, 16'h9642, 16'hF000};
    poke(16'h0005, 16'h1234);
    load(16'h0040);
    run(60, "loadstore");
    chk16("mem6 ld->st", mem[6], 16'h1234);
    chk16("mem7 collision", mem[7], 16'h2468);
    chk16("mem1 addr wrap", mem[1], 16'h2468);
    chk16("model mem6", mm[6], 16'h1234);

    // opcode 1101: BZ when enabled, NOP otherwise
    prog = '{16'hAA55, 16'hD002, 16'h9A0A, 16'h9A0B, 16'h9A0C, 16'hDA01, 16'h9A0D, 16'hF000};
    load(16'h0060);
    run(60, "bz");
`ifdef CVP14_BZ_EN
    chk16("mem10 bz taken", mem[10], 16'h0000);
    chk16("mem11 bz taken", mem[11], 16'h0000);
`else
    chk16("mem10 op D nop", mem[10], 16'h0055);
    chk16("mem11 op D nop", mem[11], 16'h0055);
`endif
    chk16("mem12 bz target", mem[12], 16'h0055);
    chk16("mem13 bz fallthru", mem[13], 16'h0055);

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) diffs++;
    chk16("memory image diffs", 16'(diffs), 16'h0000);

    // reset during a store's WR cycle: store lost, outputs and V clear at once
    prog = '{16'hA2FF, 16'hB27F, 16'h0448, 16'h940E, 16'hF000};
    load(16'h0080);
    build_trace(40);
    @(posedge Clk1); #1;
    Reset = 1'b1;
    chk_en = 1'b1;
    k = 0;
    while (WR !== 1'b1 && k < 40) begin
      @(negedge Clk1);
      k++;
    end
    chk_en = 1'b0;
    exp_q.delete();
    chk1("WR seen before abort", WR, 1'b1);
    chk1("V before abort", V, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk1("abort RD", RD, 1'b0);
    chk1("abort WR", WR, 1'b0);
    chk16("abort Addr", Addr, 16'h0000);
    chk16("abort DataOut", DataOut, 16'h0000);
    chk1("abort V", V, 1'b0);
    @(posedge Clk1); #1;
    chk16("aborted store mem14", mem[14], 16'h0000);
    Reset = 1'b1;
    @(negedge Clk1);
    chk1("idle RD after release", RD, 1'b0);
    chk16("idle Addr after release", Addr, 16'h0000);
    @(negedge Clk1);
    chk1("fetch RD after idle", RD, 1'b1);
    chk16("fetch Addr = RESET_PC", Addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cvp14_core.md
# cvp14_core

Small 16-bit multi-cycle processor core with a single-port word-addressed memory interface. It fetches 16-bit instructions from external DRAM (64K × 16, word addressed). It executes them on an 8-entry register file and reports signed arithmetic overflow on `V`. It is the top-level compute block of the system and talks directly to the memory model over a shared address bus with separate read and write strobes.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `Clk1`  in  1: sole clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `DataIn`  in  16: read data from DRAM.
- `Addr`  out  16: memory word address.
- `RD`  out  1: read strobe.
- `WR`  out  1: write strobe; DRAM writes `DataOut` to `Addr` at the rising edge.
- `DataOut`  out  16: write data to DRAM.
- `V`  out  1: overflow flag (registered).

## Operation
- **Memory contract:** DRAM samples `Addr`/`RD` at a rising edge. `DataIn` holds that word from the following cycle until the next read.
- **Registers:** R0–R7 (R0 is writable), PC (16 bits), IR, V.
- **Instruction fields:** `op` = [15:12], `rd` = [11:9], `rs` = [8:6], `rt` = [5:3], `imm6` = [5:0] (zero-extended), `imm8` = [7:0], `off12` = [11:0] (sign-extended).
- **Opcodes:**
  - 0000 ADD: rd = rs + rt; V = signed overflow.
  - 0001 SUB: rd = rs − rt; V = signed overflow.
  - 0010 AND: rd = rs & rt.
  - 0011 OR: rd = rs | rt.
  - 1000 LD: rd = M[rs + imm6].
  - 1001 ST: M[rs + imm6] = rd.
  - 1010 SLL: rd[7:0] = imm8; upper byte kept.
  - 1011 SLH: rd[15:8] = imm8; lower byte kept.
  - 1100 J: PC = PC + 1 + off12.
  - 1110 NOP.
  - 1111 HALT.
  - All other opcodes execute as NOP.
- **Width rules:** all arithmetic is mod 2^16. Address wraps at 0xFFFF. V changes only on ADD/SUB.
- **States:**
  - IDLE: `RD` = `WR` = 0, `Addr` = 0. Goes to FETCH next edge.
  - FETCH: `RD` = 1, `Addr` = PC. Goes to EXEC.
  - EXEC: decode from `DataIn` and latch it into IR; PC ← PC + 1, or the jump target for J.
    - ALU/SLL/SLH/NOP/J: write back at this edge, then FETCH.
    - LD: `RD` = 1, `Addr` = rs + imm6, then LDWB.
    - ST: `WR` = 1, `Addr` = rs + imm6, `DataOut` = R[rd], then FETCH.
    - HALT: go to HALTED.
  - LDWB: R[IR.rd] ← `DataIn`, then FETCH.
  - HALTED: `RD` = `WR` = 0; stays there until reset.
- **Outputs:**
  - `RD`, `WR`, `Addr` and `DataOut` are combinational from state, IR/`DataIn` and the register file.
  - `DataOut` = 0 and `Addr` = 0 whenever the state does not drive them.
  - `RD` and `WR` are never both 1.

## Timing
- **Reset** (`Reset` = 0, asynchronous): state = IDLE, PC = `RESET_PC`, R0–R7 = 0, IR = 0, V = 0. Outputs `RD` = `WR` = 0, `Addr` = 0, `DataOut` = 0 immediately.
- **After release:** 1 cycle in IDLE, then FETCH at `RESET_PC`.
- **Instruction latency:**
  - ALU/SLL/SLH/J/NOP/ST: 2 cycles.
  - LD: 3 cycles.
- **Reset mid-LD or mid-ST:** the access is aborted combinationally. A write is lost unless the `WR` edge has already occurred.
- **Source/destination collision:** a source register equal to the destination reads the old value; the write lands at the end of the cycle.

## Configuration
- **`CVP14_BZ_EN` defined:** opcode 1101 is BZ, i.e. `if R[rd] == 0` then PC = PC + 1 + sext([8:0]`)`, else PC + 1. It takes 2 cycles.
- **`CVP14_BZ_EN` undefined:** 1101 is a NOP.

## Test plan
- **Reset:** `Reset` low mid-run → `RD` = `WR` = 0, `Addr` = 0, V = 0 at once. After release, one IDLE cycle, then `RD` = 1 with `Addr` = 0.
- **Overflow:** SLL R1,0xFF; SLH R1,0x7F; ADD R2,R1,R1; ST R2,[R0+5] → `WR` pulse with `Addr` = 5 and `DataOut` = 0xFFFE; mem[5] = 0xFFFE; `V` = 1.
- **Load/store:** mem[5] = 0x1234; LD R3,[R0+5]; ST R3,[R0+6] → one `RD` cycle at `Addr` 5; mem[6] = 0x1234; LD takes 3 cycles.
- **Jump and halt:** J +1 skips the next word. HALT → `RD`/`WR` stay 0 for 100 cycles, memory unchanged, PC frozen.
- **Subtract overflow clear:** SUB R4,R0,R0 after an overflow → R4 = 0, V = 0. AND/OR leave V unchanged.
- **Branch (`CVP14_BZ_EN`):** BZ R0,+2 taken. BZ on a nonzero register falls through. With the macro undefined, opcode 1101 is a NOP.
